// File: rtl/char_jump_ctl.sv
// SkyHop character jump/position controller: divides movement ticks into physics
// steps, runs the charge-and-release jump FSM and integrates character position.
module char_jump_ctl #(
    parameter int unsigned STEP_PERIOD = 10,
    parameter int unsigned V_BASE      = 4,
    parameter int unsigned CHARGE_MAX  = 12,
    parameter int unsigned X_START     = 400,
    parameter int unsigned Y_START     = 500,
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = 768
) (
    input  logic        clk_40MHz,
    input  logic        rst,
    input  logic        movement_tick,
    input  logic        jump_btn,
    input  logic        dir_left,
    input  logic        dir_right,
    input  logic [11:0] floor_y,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        in_air,
    output logic [3:0]  charge_level
);

    localparam int unsigned PW  = 12;
    localparam int unsigned SW  = PW + 1;
    localparam int unsigned VW  = 8;
    localparam int unsigned CHW = 4;
    localparam int unsigned CW  = ($clog2(STEP_PERIOD) > 5) ? $clog2(STEP_PERIOD) : 5;

    localparam logic signed [SW-1:0] XMIN_S = SW'(X_MIN);
    localparam logic signed [SW-1:0] XMAX_S = SW'(X_MAX);
    localparam logic signed [VW-1:0] VY_MAX = 8'sd15;

    typedef enum logic [1:0] {IDLE, CHARGE, AIR} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          step_cnt_q, step_cnt_d;
    logic signed [VW-1:0]   vy_q, vy_d;
    logic signed [1:0]      dx_q, dx_d;
    logic [CHW-1:0]         charge_q, charge_d;
    logic [PW-1:0]          xpos_q, xpos_d;
    logic [PW-1:0]          ypos_q, ypos_d;
    logic                   in_air_q, in_air_d;

    logic                   step_c;
    logic                   floor_below_c;
    logic                   floor_above_c;
    logic signed [SW-1:0]   y_n_c;
    logic signed [SW-1:0]   x_n_c;
    logic signed [SW-1:0]   floor_s_c;
    logic [VW-1:0]          launch_mag_c;
    logic signed [1:0]      launch_dx_c;

    // Step strobe and position arithmetic shared by the state logic
    always_comb begin
        step_c        = movement_tick && (step_cnt_q == CW'(STEP_PERIOD - 1));
        floor_below_c = floor_y > ypos_q;
        floor_above_c = floor_y < ypos_q;
        y_n_c         = $signed({1'b0, ypos_q}) + SW'(vy_q);
        x_n_c         = $signed({1'b0, xpos_q}) + SW'(dx_q);
        floor_s_c     = $signed({1'b0, floor_y});
        launch_mag_c  = VW'(V_BASE) + {{(VW-CHW){1'b0}}, charge_q};
        if (dir_right && !dir_left) begin
            launch_dx_c = 2'sb01;
        end else if (dir_left && !dir_right) begin
            launch_dx_c = 2'sb11;
        end else begin
            launch_dx_c = 2'sb00;
        end
    end

    // Next-state logic; everything except the tick divider moves only on step
    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        vy_d       = vy_q;
        dx_d       = dx_q;
        charge_d   = charge_q;
        xpos_d     = xpos_q;
        ypos_d     = ypos_q;

        if (movement_tick) begin
            step_cnt_d = step_c ? '0 : step_cnt_q + CW'(1);
        end

        if (step_c) begin
            case (state_q)
                IDLE: begin
                    if (jump_btn) begin
                        state_d  = CHARGE;
                        charge_d = '0;
                    end else if (floor_below_c) begin
                        state_d = AIR;
                        vy_d    = '0;
                        dx_d    = '0;
                    end else if (floor_above_c) begin
                        ypos_d = floor_y;
                    end
                end
                CHARGE: begin
                    // Losing the floor overrides the button and drops the charge
                    if (floor_below_c) begin
                        state_d  = AIR;
                        vy_d     = '0;
                        dx_d     = '0;
                        charge_d = '0;
                    end else begin
                        if (floor_above_c) begin
                            ypos_d = floor_y;
                        end
                        if (jump_btn) begin
                            charge_d = (charge_q >= CHW'(CHARGE_MAX)) ? CHW'(CHARGE_MAX)
                                                                       : charge_q + CHW'(1);
                        end else begin
                            state_d  = AIR;
                            vy_d     = -$signed(launch_mag_c);
                            dx_d     = launch_dx_c;
                            charge_d = '0;
                        end
                    end
                end
                AIR: begin
                    if ((vy_q > 8'sd0) && (y_n_c >= floor_s_c)) begin
                        ypos_d  = floor_y;
                        vy_d    = '0;
                        state_d = IDLE;
                    end else if (y_n_c < 13'sd0) begin
                        ypos_d = '0;
                        vy_d   = '0;
                    end else begin
                        ypos_d = y_n_c[PW-1:0];
                        vy_d   = (vy_q >= VY_MAX) ? VY_MAX : vy_q + 8'sd1;
                    end
                    if (x_n_c < XMIN_S) begin
                        xpos_d = XMIN_S[PW-1:0];
                    end else if (x_n_c > XMAX_S) begin
                        xpos_d = XMAX_S[PW-1:0];
                    end else begin
                        xpos_d = x_n_c[PW-1:0];
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        in_air_d = (state_d == AIR);
    end

    always_ff @(posedge clk_40MHz) begin
        if (rst) begin
            state_q    <= IDLE;
            step_cnt_q <= '0;
            vy_q       <= '0;
            dx_q       <= '0;
            charge_q   <= '0;
            xpos_q     <= PW'(X_START);
            ypos_q     <= PW'(Y_START);
            in_air_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            vy_q       <= vy_d;
            dx_q       <= dx_d;
            charge_q   <= charge_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            in_air_q   <= in_air_d;
        end
    end

    assign xpos         = xpos_q;
    assign ypos         = ypos_q;
    assign in_air       = in_air_q;
    assign charge_level = charge_q;

endmodule

// File: tb/tb_char_jump_ctl.sv
// Directed bench for char_jump_ctl: reset, walk-off, charged jumps, drift, edge
// clamp, ceiling hit and button hold through landing.
`timescale 1ns/1ps
module tb_char_jump_ctl;

    logic        clk_40MHz = 1'b0;
    logic        rst;
    logic        movement_tick;
    logic        jump_btn;
    logic        dir_left;
    logic        dir_right;
    logic [11:0] floor_y;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        in_air;
    logic [3:0]  charge_level;

    int passed = 0;
    int total  = 0;

    char_jump_ctl dut (
        .clk_40MHz    (clk_40MHz),
        .rst          (rst),
        .movement_tick(movement_tick),
        .jump_btn     (jump_btn),
        .dir_left     (dir_left),
        .dir_right    (dir_right),
        .floor_y      (floor_y),
        .xpos         (xpos),
        .ypos         (ypos),
        .in_air       (in_air),
        .charge_level (charge_level)
    );

    always #5 clk_40MHz = ~clk_40MHz;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        movement_tick = 1'b1;
        @(negedge clk_40MHz);
        movement_tick = 1'b0;
        @(negedge clk_40MHz);
    endtask

    task automatic step();
        repeat (10) tick();
    endtask

    // Charge for n_high steps, release with the given drift, fly until landing
    task automatic do_jump(input int n_high, input logic right, output int air_steps);
        jump_btn = 1'b1;
        repeat (n_high) step();
        jump_btn  = 1'b0;
        dir_right = right;
        step();
        dir_right = 1'b0;
        chk("jump_launch_in_air", 16'(in_air), 16'd1);
        air_steps = 0;
        while (in_air && air_steps < 40) begin
            step();
            air_steps++;
        end
    endtask

    int walk_y [10] = '{500, 501, 503, 506, 510, 515, 521, 528, 536, 540};
    int vert_y [15] = '{493, 487, 482, 478, 475, 473, 472, 472, 473, 475, 478, 482, 487, 493, 500};
    int ceil_y [5]  = '{0, 0, 1, 3, 5};
    int n_air;

    initial begin
        rst           = 1'b1;
        movement_tick = 1'b0;
        jump_btn      = 1'b0;
        dir_left      = 1'b0;
        dir_right     = 1'b0;
        floor_y       = 12'd540;
        @(negedge clk_40MHz);
        repeat (5) begin
            movement_tick = ~movement_tick;
            @(negedge clk_40MHz);
        end
        rst           = 1'b0;
        movement_tick = 1'b0;
        chk("rst_xpos", 16'(xpos), 16'd400);
        chk("rst_ypos", 16'(ypos), 16'd500);
        chk("rst_in_air", 16'(in_air), 16'd0);
        chk("rst_charge", 16'(charge_level), 16'd0);

        // First step lands on the tenth tick after reset: walk-off becomes visible
        repeat (9) tick();
        chk("pre_step_in_air", 16'(in_air), 16'd0);
        tick();
        chk("first_step_in_air", 16'(in_air), 16'd1);
        chk("first_step_ypos", 16'(ypos), 16'd500);

        for (int k = 0; k < 10; k++) begin
            step();
            chk("walk_ypos", 16'(ypos), 16'(walk_y[k]));
            chk("walk_in_air", 16'(in_air), (k < 9) ? 16'd1 : 16'd0);
        end
        chk("walk_xpos", 16'(xpos), 16'd400);

        // Snap up to a higher floor
        floor_y = 12'd500;
        step();
        chk("snap_ypos", 16'(ypos), 16'd500);
        chk("snap_in_air", 16'(in_air), 16'd0);

        // Charged vertical jump, launch vy = -7
        jump_btn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("vert_charge", 16'(charge_level), 16'(i));
        end
        jump_btn = 1'b0;
        step();
        chk("vert_launch_in_air", 16'(in_air), 16'd1);
        chk("vert_launch_charge", 16'(charge_level), 16'd0);
        chk("vert_launch_ypos", 16'(ypos), 16'd500);
        for (int k = 0; k < 15; k++) begin
            step();
            chk("vert_ypos", 16'(ypos), 16'(vert_y[k]));
            chk("vert_in_air", 16'(in_air), (k < 14) ? 16'd1 : 16'd0);
        end
        chk("vert_xpos", 16'(xpos), 16'd400);

        // Saturated charge with right drift, launch vy = -16, 34 air steps
        jump_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("sat_charge", 16'(charge_level), (i < 12) ? 16'(i) : 16'd12);
        end
        jump_btn  = 1'b0;
        dir_right = 1'b1;
        step();
        dir_right = 1'b0;
        chk("sat_launch_in_air", 16'(in_air), 16'd1);
        chk("sat_launch_xpos", 16'(xpos), 16'd400);
        for (int k = 1; k <= 34; k++) begin
            step();
            chk("sat_xpos", 16'(xpos), 16'(400 + k));
            if (k == 1) chk("sat_first_ypos", 16'(ypos), 16'd484);
            chk("sat_in_air", 16'(in_air), (k < 34) ? 16'd1 : 16'd0);
        end
        chk("sat_land_ypos", 16'(ypos), 16'd500);

        // Drift right to x = 767: nine saturated jumps then one of vy = -13
        for (int j = 0; j < 9; j++) begin
            do_jump(13, 1'b1, n_air);
            chk("hop_air_steps", 16'(n_air), 16'd34);
            chk("hop_land_x", 16'(xpos), 16'(434 + 34 * (j + 1)));
        end
        do_jump(10, 1'b1, n_air);
        chk("hop13_air_steps", 16'(n_air), 16'd27);
        chk("hop13_land_x", 16'(xpos), 16'd767);

        // Edge clamp: from 767 with dx = +1, x pins at 768
        jump_btn = 1'b1;
        repeat (4) step();
        jump_btn  = 1'b0;
        dir_right = 1'b1;
        step();
        dir_right = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            chk("edge_xpos", 16'(xpos), 16'd768);
            chk("edge_ypos", 16'(ypos), 16'(vert_y[k]));
        end
        chk("edge_in_air", 16'(in_air), 16'd0);

        // Ceiling: snap up to y = 5, launch vy = -6 while holding button in air
        floor_y = 12'd5;
        step();
        chk("ceil_snap_ypos", 16'(ypos), 16'd5);
        jump_btn = 1'b1;
        repeat (3) step();
        chk("ceil_charge", 16'(charge_level), 16'd2);
        jump_btn = 1'b0;
        step();
        chk("ceil_launch_in_air", 16'(in_air), 16'd1);
        jump_btn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("ceil_ypos", 16'(ypos), 16'(ceil_y[k]));
            chk("ceil_in_air", 16'(in_air), (k < 4) ? 16'd1 : 16'd0);
        end
        chk("ceil_xpos", 16'(xpos), 16'd768);

        // Button held through landing starts a fresh charge
        step();
        chk("hold_in_air", 16'(in_air), 16'd0);
        chk("hold_charge0", 16'(charge_level), 16'd0);
        step();
        chk("hold_charge1", 16'(charge_level), 16'd1);

        // Reset wins over steps arriving while it is held
        rst = 1'b1;
        repeat (10) tick();
        rst = 1'b0;
        chk("rst2_xpos", 16'(xpos), 16'd400);
        chk("rst2_ypos", 16'(ypos), 16'd500);
        chk("rst2_charge", 16'(charge_level), 16'd0);
        chk("rst2_in_air", 16'(in_air), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
